instr_fetch: RTL

//  Instruction-fetch stage directly upstream of the datapath. Owns the PC, reads one
//  32-bit word per instruction from instruction memory over a req/ack handshake and

---
 rtl/instr_fetch.sv | 46 ++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, fetches one word per instruction over req/ack, computes next PC
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        Zero,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);
  typedef enum logic {REQ, ISSUE} state_t;
  state_t state;
  logic [31:0] next_pc;
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req = (state == REQ) && !rst;
  assign instr_valid = state == ISSUE;
  always_comb
    next_pc = jump ? {pc_plus4[31:28], instruction[25:0], 2'b00} :
              (branch && Zero) ? pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00} :
              pc_plus4;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= REQ;
      pc <= RESET_PC;
      instruction <= NOP_WORD;
    end else if (state == REQ) begin
      if (imem_ack) begin
        instruction <= imem_rdata;
        state <= ISSUE;
      end
    end else if (!stall) begin
      pc <= next_pc;
      state <= REQ;
    end
endmodule
